// File: rtl/thor2021_pkg.sv
// Thor2021 shared types and constants.
// Instruction width, NOP and postfix opcodes used by fetch/decode.
package Thor2021_pkg;

  typedef logic [47:0] Instruction;

  localparam logic [7:0] EXI7  = 8'h50;
  localparam logic [7:0] EXI23 = 8'h51;
  localparam logic [7:0] EXI41 = 8'h52;

  localparam Instruction NOP_INSN = 48'h0000_0000_00EA;

  typedef enum logic {
    ALIGN,
    STREAM
  } align_state_e;

  function automatic logic is_exi(
    input logic [7:0] op
  );
    return (op == EXI7) ||
           (op == EXI23) ||
           (op == EXI41);
  endfunction

endpackage

// File: rtl/thor2021_insn_aligner.sv
// Thor2021 instruction aligner: 32-byte byte queue between
// the 16-byte fetch port and the decoder, with postfix pairing.
module thor2021_insn_aligner
  import Thor2021_pkg::*;
#(
  parameter logic [63:0] RSTPC = 64'hFFFFFFFFFFFC0100
) (
  input  logic         rst_i,
  input  logic         clk_i,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  logic [127:0] fetch_dat_i,
  input  logic         redirect_i,
  input  logic [63:0]  redirect_pc_i,
  output Instruction   ir_o,
  output Instruction   xir_o,
  output logic [63:0]  pc_o,
  output logic [3:0]   len_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [255:0] q;
  logic [5:0]   cnt;
  logic [63:0]  hpc;
  align_state_e st;

  logic         exi;
  logic         pop;
  logic         push;
  logic [3:0]   popn;
  logic [3:0]   skip;
  logic [4:0]   alen;
  logic [5:0]   cnt_mid;
  logic [5:0]   cnt_nx;
  logic [127:0] wsh;
  logic [255:0] qsh;
  logic [255:0] qnx;

  always_comb begin
    exi   = is_exi(q[55:48]);
    len_o = exi ? 4'd12 : 4'd6;
    ir_o  = q[47:0];
    xir_o = exi ? q[95:48] : NOP_INSN;
    pc_o  = hpc;

    valid_o       = (cnt >= 6'd12) && !redirect_i;
    fetch_ready_o = (cnt <= 6'd16) && !redirect_i;

    pop  = valid_o && ready_i;
    push = fetch_valid_i && fetch_ready_o;
    popn = pop ? len_o : 4'd0;
  end

  // Bytes at or above cnt are kept zero so the tail can be OR-merged.
  always_comb begin
    skip    = (st == ALIGN) ? hpc[3:0] : 4'd0;
    alen    = 5'd16 - {1'b0, skip};
    cnt_mid = cnt - {2'b00, popn};
    wsh     = fetch_dat_i >> {skip, 3'b000};
    qsh     = q >> {popn, 3'b000};
    qnx     = qsh;
    cnt_nx  = cnt_mid;
    if (push) begin
      qnx    = qsh | ({128'd0, wsh} << {cnt_mid, 3'b000});
      cnt_nx = cnt_mid + {1'b0, alen};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q   <= '0;
      cnt <= '0;
      hpc <= RSTPC;
      st  <= ALIGN;
    end else if (redirect_i) begin
      q   <= '0;
      cnt <= '0;
      hpc <= redirect_pc_i;
      st  <= ALIGN;
    end else begin
      q   <= qnx;
      cnt <= cnt_nx;
      if (pop)
        hpc <= hpc + {60'd0, len_o};
      if (push)
        st <= STREAM;
    end
  end

endmodule

// File: tb/tb_thor2021_insn_aligner.sv
// Bench for thor2021_insn_aligner: byte-stream reference model
// feeding an expected-instruction scoreboard.
module tb_thor2021_insn_aligner;
  import Thor2021_pkg::*;

  localparam logic [63:0] RSTPC = 64'hFFFFFFFFFFFC0100;

  logic         rst_i;
  logic         clk_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  logic [127:0] fetch_dat_i;
  logic         redirect_i;
  logic [63:0]  redirect_pc_i;
  Instruction   ir_o;
  Instruction   xir_o;
  logic [63:0]  pc_o;
  logic [3:0]   len_o;
  logic         valid_o;
  logic         ready_i;

  thor2021_insn_aligner #(.RSTPC(RSTPC)) dut (
    .rst_i(rst_i),
    .clk_i(clk_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_dat_i(fetch_dat_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ir_o(ir_o),
    .xir_o(xir_o),
    .pc_o(pc_o),
    .len_o(len_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    Instruction  ir;
    Instruction  xir;
    logic [63:0] pc;
    logic [3:0]  len;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mq[$];
  logic [63:0] mpc;
  bit          malign;
  int          appended;
  int          popped;
  int          npass;
  int          ntot;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    ntot++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, expv);
  endtask

  function automatic bit op_is_postfix(input logic [7:0] op);
    return op == EXI7 || op == EXI23 || op == EXI41;
  endfunction

  task automatic model_flush(input logic [63:0] pc);
    mq.delete();
    expq.delete();
    appended = 0;
    popped   = 0;
    mpc      = pc;
    malign   = 1'b1;
  endtask

  // Append a fetch word to the byte stream and carve out whole instructions.
  task automatic model_push(input logic [127:0] w);
    int s;
    exp_t e;
    s = malign ? int'(mpc[3:0]) : 0;
    for (int i = s; i < 16; i++) mq.push_back(w[8*i +: 8]);
    appended += 16 - s;
    malign = 1'b0;
    while (mq.size() >= 12) begin
      e.ir  = '0;
      e.xir = NOP_INSN;
      for (int i = 0; i < 6; i++) e.ir[8*i +: 8] = mq[i];
      if (op_is_postfix(mq[6])) begin
        for (int i = 0; i < 6; i++) e.xir[8*i +: 8] = mq[6+i];
        e.len = 4'd12;
      end else begin
        e.len = 4'd6;
      end
      e.pc = mpc;
      mpc  = mpc + 64'(e.len);
      for (int i = 0; i < int'(e.len); i++) void'(mq.pop_front());
      expq.push_back(e);
    end
  endtask

  task automatic cycle(input bit fv, input logic [127:0] d, input bit rdy,
                       input bit rd, input logic [63:0] rpc);
    int cnt;
    @(negedge clk_i);
    fetch_valid_i = fv;
    fetch_dat_i   = d;
    ready_i       = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    cnt = appended - popped;
    chk("fetch_ready", fetch_ready_o, 64'(cnt <= 16 && !rd));
    chk("valid", valid_o, 64'(cnt >= 12 && !rd));
    if (rd) model_flush(rpc);
    else if (fv && cnt <= 16) model_push(d);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i         = 1'b1;
    fetch_valid_i = 1'b0;
    ready_i       = 1'b0;
    redirect_i    = 1'b0;
    #1;
    model_flush(RSTPC);
    chk("rst_valid", valid_o, 0);
    chk("rst_fready", fetch_ready_o, 1);
    chk("rst_ir", ir_o, 0);
    chk("rst_xir", xir_o, NOP_INSN);
    chk("rst_len", len_o, 6);
    chk("rst_pc", pc_o, RSTPC);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic logic [127:0] mkw(input logic [7:0] base);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = base + 8'(i);
    return w;
  endfunction

  function automatic logic [127:0] rndw();
    logic [127:0] w;
    logic [7:0] exis [3];
    exis[0] = EXI7;
    exis[1] = EXI23;
    exis[2] = EXI41;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 5) == 0) w[8*i +: 8] = exis[$urandom_range(0, 2)];
      else w[8*i +: 8] = 8'($urandom);
    end
    return w;
  endfunction

  // Monitor: compare every pop against the scoreboard and check stall hold.
  initial begin : monitor
    exp_t e;
    bit held_v;
    Instruction h_ir;
    Instruction h_xir;
    logic [63:0] h_pc;
    logic [3:0] h_len;
    held_v = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        held_v = 1'b0;
      end else begin
        if (held_v && valid_o) begin
          chk("hold_ir", ir_o, h_ir);
          chk("hold_xir", xir_o, h_xir);
          chk("hold_pc", pc_o, h_pc);
          chk("hold_len", len_o, h_len);
        end
        if (valid_o && ready_i) begin
          if (expq.size() == 0) begin
            ntot++;
            $display("FAIL pop_unexpected: got pc %h want no pop", pc_o);
          end else begin
            e = expq.pop_front();
            chk("ir", ir_o, e.ir);
            chk("xir", xir_o, e.xir);
            chk("pc", pc_o, e.pc);
            chk("len", len_o, e.len);
            popped += int'(e.len);
          end
        end
        held_v = valid_o && !ready_i;
        h_ir   = ir_o;
        h_xir  = xir_o;
        h_pc   = pc_o;
        h_len  = len_o;
      end
    end
  end

  initial begin : driver
    logic [127:0] w;
    npass         = 0;
    ntot          = 0;
    rst_i         = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_dat_i   = '0;
    ready_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    model_flush(RSTPC);
    do_reset();

    // Two sequential words from reset PC, then drain.
    cycle(1, mkw(8'h01), 0, 0, 0);
    cycle(1, mkw(8'h11), 0, 0, 0);
    repeat (6) cycle(0, 0, 1, 0, 0);

    // Postfix pairing.
    cycle(0, 0, 0, 1, 64'h2000);
    w = mkw(8'h21);
    w[55:48] = EXI23;
    cycle(1, w, 0, 0, 0);
    cycle(1, mkw(8'h31), 0, 0, 0);
    repeat (5) cycle(0, 0, 1, 0, 0);

    // Unaligned redirect.
    cycle(0, 0, 0, 1, 64'hFFFF_0000_0000_1009);
    cycle(1, mkw(8'h61), 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, mkw(8'h71), 1, 0, 0);
    repeat (4) cycle(0, 0, 1, 0, 0);

    // Simultaneous push and pop at count 16.
    cycle(0, 0, 0, 1, 64'h3000);
    cycle(1, mkw(8'h01), 0, 0, 0);
    cycle(1, mkw(8'h11), 1, 0, 0);
    cycle(1, mkw(8'h21), 0, 0, 0);
    repeat (6) cycle(0, 0, 1, 0, 0);

    // Full queue held off for five cycles.
    cycle(0, 0, 0, 1, 64'h4000);
    cycle(1, mkw(8'h01), 0, 0, 0);
    cycle(1, mkw(8'h11), 0, 0, 0);
    repeat (5) cycle(1, mkw(8'h21), 0, 0, 0);
    repeat (6) cycle(0, 0, 1, 0, 0);

    // Redirect wins over push and pop.
    cycle(1, mkw(8'h01), 0, 0, 0);
    cycle(1, mkw(8'h11), 0, 0, 0);
    cycle(1, mkw(8'h21), 1, 1, 64'h5000);
    cycle(0, 0, 1, 0, 0);
    cycle(1, mkw(8'h31), 1, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Randomized traffic, with a PC wrap case and a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if (n == 700)
        cycle(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF5);
      else if ($urandom_range(0, 63) == 0)
        cycle($urandom_range(0, 1) == 1, rndw(), $urandom_range(0, 1) == 1,
              1, {$urandom, $urandom});
      else
        cycle($urandom_range(0, 3) != 0, rndw(),
              $urandom_range(0, 2) != 0, 0, 0);
    end

    repeat (12) cycle(0, 0, 1, 0, 0);
    chk("drain_empty", 64'(expq.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/thor2021_insn_aligner.md
THOR2021_INSN_ALIGNER -- requirements
Module: Thor2021_insn_aligner

Interface
REQ-001 SHALL have parameter RSTPC, default 64'hFFFFFFFFFFFC0100, the PC loaded at reset.
REQ-002 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port clk_i, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port fetch_valid_i, input, 1: a fetch word is offered.
REQ-005 SHALL have port fetch_ready_o, output, 1: a fetch word can be accepted this cycle.
REQ-006 SHALL have port fetch_dat_i, input, 128: 16-byte-aligned fetch word, byte 0 in [7:0].
REQ-007 SHALL have port redirect_i, input, 1: flush and restart at redirect_pc_i.
REQ-008 SHALL have port redirect_pc_i, input, 64: new byte PC.
REQ-009 SHALL have port ir_o, input-side of decoder, output, 48: Instruction at head.
REQ-010 SHALL have port xir_o, output, 48: postfix Instruction, or NOP_INSN when no postfix.
REQ-011 SHALL have port pc_o, output, 64: byte address of ir_o.
REQ-012 SHALL have port len_o, output, 4: bytes consumed on pop, 6 or 12.
REQ-013 SHALL have port valid_o, output, 1: ir_o/xir_o/pc_o/len_o are valid.
REQ-014 SHALL have port ready_i, input, 1: decoder takes the head; pop occurs when valid_o && ready_i.

Function
REQ-015 SHALL hold a 32-byte byte queue with a 6-bit count (0..32) and a 64-bit head PC.
REQ-016 SHALL drive fetch_ready_o = (count <= 16) && !redirect_i, from registered count only.
REQ-017 SHALL accept a fetch word when fetch_valid_i && fetch_ready_o, appending its bytes behind the current tail.
REQ-018 SHALL implement states STREAM and ALIGN; in ALIGN, the first accepted word drops its low skip = head_pc[3:0] bytes (appends 16-skip bytes) and the state moves to STREAM; STREAM appends all 16 bytes.
REQ-019 SHALL drive valid_o = (count >= 12) && !redirect_i; ir_o = queue bytes 0..5.
REQ-020 SHALL treat bytes 6..11 as a postfix when their opcode field [7:0] is EXI7, EXI23 or EXI41: xir_o = those bytes, len_o = 12; otherwise xir_o = NOP_INSN, len_o = 6.
REQ-021 SHALL treat an EXI opcode in ir_o position as an ordinary 6-byte instruction.
REQ-022 SHALL on pop shift the queue by len_o bytes, subtract len_o from count, add len_o to head PC (64-bit wrap).
REQ-023 SHALL handle simultaneous push and pop in one cycle: count_next = count - popped + appended; data order preserved.
REQ-024 SHALL give one-cycle latency: a word accepted at edge N yields valid_o during cycle N+1 if count reaches 12.
REQ-025 SHALL on redirect_i (priority over push and pop): count <= 0, head PC <= redirect_pc_i, state <= ALIGN; any same-cycle fetch word and pop are ignored.
REQ-026 SHALL hold all outputs stable while valid_o && !ready_i.
REQ-027 SHALL never overflow: count never exceeds 32 given REQ-016.

Reset
REQ-028 SHALL on rst_i asserted: count = 0, head PC = RSTPC, state = ALIGN, queue bytes = 0.
REQ-029 SHALL then present valid_o = 0, fetch_ready_o = 1, ir_o = 0, xir_o = NOP_INSN, len_o = 6, pc_o = RSTPC.
REQ-030 SHALL abandon any partially buffered or in-flight instruction when rst_i asserts mid-operation.

Structure
REQ-031 SHALL place NOP_INSN, EXI7/EXI23/EXI41 opcodes and the Instruction type in Thor2021_pkg, and SHALL add no duplicate definitions locally.
REQ-032 SHALL use the Thor2021_pkg Instruction type for ir_o and xir_o so they connect directly to the decoder's ir/xir.
REQ-033 SHALL be a single module; the byte-queue shifter is inline (no sub-module).

Verification
REQ-034 SHALL test reset with RSTPC=...0100, then words 0x..0100 and 0x..0110 pushed -> first pop pc_o=...0100, len_o=6, second pc_o=...0106.
REQ-035 SHALL test instruction at bytes 0..5 followed by an EXI23 at bytes 6..11 -> xir_o = the EXI23 bytes, len_o=12, next pc_o advances by 12.
REQ-036 SHALL test redirect to 64'h...1009 -> first word appends 7 bytes; valid_o stays 0 until count>=12; first pc_o=...1009.
REQ-037 SHALL test count=16 with push and pop of 6 in the same cycle -> count=26, byte order intact, fetch_ready_o=0 next cycle.
REQ-038 SHALL test ready_i=0 for 5 cycles with count=32 -> fetch_ready_o=0, outputs unchanged, no data loss.
REQ-039 SHALL test redirect_i asserted together with fetch_valid_i and ready_i -> word dropped, no pop, count=0, state=ALIGN.
